// File: rtl/tetris_board_pkg.sv
// Shared playfield constants, FSM state type and line-clear score table.
// The score table is used only by line_clear_score, which is built when
// LINE_CLEAR_SCORE_EN is defined.
package tetris_board_pkg;

   localparam int ROWS    = 20;
   localparam int COLS    = 10;
   localparam int CELL_W  = 3;
   localparam int ROW_W   = 5;
   localparam int COL_W   = 4;
   localparam int LINES_W = 5;
   localparam int SCORE_W = 16;

   localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);
   localparam logic [CELL_W-1:0] EMPTY_CELL = '0;

   localparam logic [SCORE_W-1:0] SCORE_0 = 16'd0;
   localparam logic [SCORE_W-1:0] SCORE_1 = 16'd40;
   localparam logic [SCORE_W-1:0] SCORE_2 = 16'd100;
   localparam logic [SCORE_W-1:0] SCORE_3 = 16'd300;
   localparam logic [SCORE_W-1:0] SCORE_4 = 16'd1200;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_SHIFT,
      ST_CLEAR_TOP,
      ST_DONE
   } state_e;

   // Points awarded for one pass; four or more lines share the top award.
   function automatic logic [SCORE_W-1:0] line_points(input logic [LINES_W-1:0] lines);
      logic [SCORE_W-1:0] pts;
      case (lines)
         5'd0:    pts = SCORE_0;
         5'd1:    pts = SCORE_1;
         5'd2:    pts = SCORE_2;
         5'd3:    pts = SCORE_3;
         default: pts = SCORE_4;
      endcase
      return pts;
   endfunction

endpackage

// File: rtl/board_line_clear_ctrl_if.sv
// Control handshake and board-storage port pair of the line-clear sequencer.
//
// Handshake: start is a one-cycle request, accepted only while busy is low;
// busy rises the cycle after acceptance and stays high through the cycle in
// which done pulses. lines_cleared is valid from done until the next pass
// ends. The board read is combinational (rd_data follows rd_row/rd_col in the
// same cycle); the board write happens on the clock edge where wr_en is high.
interface board_line_clear_ctrl_if;
   import tetris_board_pkg::*;

   logic                 start;
   logic                 busy;
   logic                 done;
   logic [LINES_W-1:0]   lines_cleared;
   logic [ROW_W-1:0]     rd_row;
   logic [COL_W-1:0]     rd_col;
   logic [CELL_W-1:0]    rd_data;
   logic                 wr_en;
   logic [ROW_W-1:0]     wr_row;
   logic [COL_W-1:0]     wr_col;
   logic [CELL_W-1:0]    wr_data;
   logic [SCORE_W-1:0]   score;

   // Sequencer side.
   modport master (
      input  start, rd_data,
      output busy, done, lines_cleared, rd_row, rd_col,
             wr_en, wr_row, wr_col, wr_data, score
   );

   // Game FSM / board storage side.
   modport slave (
      output start, rd_data,
      input  busy, done, lines_cleared, rd_row, rd_col,
             wr_en, wr_row, wr_col, wr_data, score
   );

endinterface

// File: rtl/line_clear_score.sv
// Lines-to-points lookup with a saturating 16-bit score accumulator.
// The module only exists when LINE_CLEAR_SCORE_EN is defined.
`ifdef LINE_CLEAR_SCORE_EN
module line_clear_score
   import tetris_board_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                i_add_en,
   input  logic [LINES_W-1:0]  i_lines,
   output logic [SCORE_W-1:0]  o_score
);

   logic [SCORE_W-1:0] r_score;
   logic [SCORE_W:0]   w_sum;

   // One extra bit catches overflow for saturation.
   always_comb begin
      w_sum = {1'b0, r_score} + {1'b0, line_points(i_lines)};
   end

   // Accumulate once per pass; only reset clears the score.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_score <= '0;
      end else if (i_add_en) begin
         r_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
      end
   end

   assign o_score = r_score;

endmodule
`endif

// File: rtl/board_line_clear_ctrl.sv
// Line-clear sequencer for the 20x10 playfield. Scans rows bottom-up, removes
// each full row by shifting everything above it down one row, blanks the top
// row, and rescans the same row index. Optional score keeping is enabled by
// defining LINE_CLEAR_SCORE_EN; otherwise score is tied to zero.
module board_line_clear_ctrl
   import tetris_board_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   board_line_clear_ctrl_if.master bus,
   output state_e                  dbg_state
);

   state_e               r_state,  w_state_nxt;
   logic [ROW_W-1:0]     r_row,    w_row_nxt;
   logic [ROW_W-1:0]     r_dst,    w_dst_nxt;
   logic [COL_W-1:0]     r_col,    w_col_nxt;
   logic [LINES_W-1:0]   r_lines,  w_lines_nxt;
   logic [LINES_W-1:0]   r_lines_cleared, w_lines_cleared_nxt;

   logic [ROW_W-1:0]     w_rd_row;
   logic [COL_W-1:0]     w_rd_col;
   logic                 w_wr_en;
   logic [ROW_W-1:0]     w_wr_row;
   logic [COL_W-1:0]     w_wr_col;
   logic [CELL_W-1:0]    w_wr_data;
   logic [SCORE_W-1:0]   w_score;

   // State and datapath registers; reset aborts a pass on the spot.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_row           <= '0;
         r_dst           <= '0;
         r_col           <= '0;
         r_lines         <= '0;
         r_lines_cleared <= '0;
      end else begin
         r_state         <= w_state_nxt;
         r_row           <= w_row_nxt;
         r_dst           <= w_dst_nxt;
         r_col           <= w_col_nxt;
         r_lines         <= w_lines_nxt;
         r_lines_cleared <= w_lines_cleared_nxt;
      end
   end

   // Next-state and board-port decode.
   always_comb begin
      w_state_nxt         = r_state;
      w_row_nxt           = r_row;
      w_dst_nxt           = r_dst;
      w_col_nxt           = r_col;
      w_lines_nxt         = r_lines;
      w_lines_cleared_nxt = r_lines_cleared;
      w_rd_row            = '0;
      w_rd_col            = '0;
      w_wr_en             = 1'b0;
      w_wr_row            = '0;
      w_wr_col            = '0;
      w_wr_data           = EMPTY_CELL;

      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_row_nxt   = LAST_ROW;
               w_col_nxt   = '0;
               w_lines_nxt = '0;
               w_state_nxt = ST_SCAN;
            end
         end

         ST_SCAN: begin
            w_rd_row = r_row;
            w_rd_col = r_col;
            if (bus.rd_data == EMPTY_CELL) begin
               // A hole ends this row's scan early.
               if (r_row == '0) begin
                  // Final count is latched on entry so it is valid with done.
                  w_lines_cleared_nxt = r_lines;
                  w_state_nxt         = ST_DONE;
               end else begin
                  w_row_nxt = r_row - 5'd1;
                  w_col_nxt = '0;
               end
            end else if (r_col == LAST_COL) begin
               w_dst_nxt   = r_row;
               w_col_nxt   = '0;
               w_state_nxt = (r_row == '0) ? ST_CLEAR_TOP : ST_SHIFT;
            end else begin
               w_col_nxt = r_col + 4'd1;
            end
         end

         ST_SHIFT: begin
            // Copy the cell directly above into the destination row.
            w_rd_row  = r_dst - 5'd1;
            w_rd_col  = r_col;
            w_wr_en   = 1'b1;
            w_wr_row  = r_dst;
            w_wr_col  = r_col;
            w_wr_data = bus.rd_data;
            if (r_col == LAST_COL) begin
               w_col_nxt = '0;
               if (r_dst == 5'd1) begin
                  w_state_nxt = ST_CLEAR_TOP;
               end else begin
                  w_dst_nxt = r_dst - 5'd1;
               end
            end else begin
               w_col_nxt = r_col + 4'd1;
            end
         end

         ST_CLEAR_TOP: begin
            w_wr_en   = 1'b1;
            w_wr_row  = '0;
            w_wr_col  = r_col;
            w_wr_data = EMPTY_CELL;
            if (r_col == LAST_COL) begin
               // Row index is kept so the row that moved down gets rescanned.
               w_lines_nxt = r_lines + 5'd1;
               w_col_nxt   = '0;
               w_state_nxt = ST_SCAN;
            end else begin
               w_col_nxt = r_col + 4'd1;
            end
         end

         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

`ifdef LINE_CLEAR_SCORE_EN
   line_clear_score u_score (
      .clk      (clk),
      .reset    (reset),
      .i_add_en (r_state == ST_DONE),
      .i_lines  (r_lines),
      .o_score  (w_score)
   );
`else
   assign w_score = '0;
`endif

   assign bus.busy          = (r_state != ST_IDLE);
   assign bus.done          = (r_state == ST_DONE);
   assign bus.lines_cleared = r_lines_cleared;
   assign bus.rd_row        = w_rd_row;
   assign bus.rd_col        = w_rd_col;
   assign bus.wr_en         = w_wr_en;
   assign bus.wr_row        = w_wr_row;
   assign bus.wr_col        = w_wr_col;
   assign bus.wr_data       = w_wr_data;
   assign bus.score         = w_score;
   assign dbg_state         = r_state;

endmodule

// File: tb/tb_board_line_clear_ctrl.sv
// Bench for board_line_clear_ctrl: board memory model, directed and random
// passes checked against a row-compaction reference and a score model.
module tb_board_line_clear_ctrl;
  import tetris_board_pkg::*;

  localparam int TIMEOUT = 10000;

  logic   clk;
  logic   reset;
  state_e dbg_state;

  board_line_clear_ctrl_if bus();

  board_line_clear_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- board storage model ----------------
  logic [CELL_W-1:0] board    [ROWS][COLS];
  logic [CELL_W-1:0] load_img [ROWS][COLS];
  logic [CELL_W-1:0] exp_board[ROWS][COLS];
  logic              load_en;

  assign bus.rd_data = (int'(bus.rd_row) < ROWS && int'(bus.rd_col) < COLS) ?
                       board[int'(bus.rd_row)][int'(bus.rd_col)] : '0;

  always @(posedge clk) begin
    if (load_en) board <= load_img;
    else if (bus.wr_en) board[int'(bus.wr_row)][int'(bus.wr_col)] <= bus.wr_data;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [LINES_W-1:0] exp_q[$];
  int exp_score = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  function automatic int points(input int lines);
    if (lines == 0) return 0;
    if (lines == 1) return 40;
    if (lines == 2) return 100;
    if (lines == 3) return 300;
    return 1200;
  endfunction

  // Reference: a pass removes every full row and lets the rest fall,
  // keeping their order, with empty rows filling in on top.
  task automatic compute_expected(output int lines);
    int dst;
    bit full;
    lines = 0;
    dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (board[r][c] == 0) full = 1'b0;
      if (full) lines++;
      else begin
        for (int c = 0; c < COLS; c++) exp_board[dst][c] = board[r][c];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--)
      for (int c = 0; c < COLS; c++) exp_board[r][c] = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_score = 0;
  endtask

  task automatic load_board();
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic fill_empty();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) load_img[r][c] = '0;
  endtask

  task automatic fill_row(input int r, input int v);
    for (int c = 0; c < COLS; c++) load_img[r][c] = CELL_W'(v);
  endtask

  task automatic fill_random();
    int kind;
    for (int r = 0; r < ROWS; r++) begin
      kind = $urandom_range(0, 3);
      for (int c = 0; c < COLS; c++) begin
        if (kind == 0) load_img[r][c] = '0;
        else if (kind == 1) load_img[r][c] = CELL_W'($urandom_range(1, 7));
        else load_img[r][c] = CELL_W'($urandom_range(0, 7));
      end
      if (kind >= 2) load_img[r][$urandom_range(0, COLS - 1)] = '0;
    end
  endtask

  // start sampled in cycle 0; extra_cyc re-pulses start in that cycle.
  task automatic run_pass(input int extra_cyc, output int done_cyc,
                          output int busy_cnt, output int wr_cnt);
    bit seen;
    seen = 1'b0;
    done_cyc = 0;
    busy_cnt = 0;
    wr_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == extra_cyc);
      if (bus.busy) busy_cnt++;
      if (bus.wr_en) wr_cnt++;
      if (bus.done) begin
        done_cyc = cyc;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("pass_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_pass(input string tag, input int extra_cyc,
                            output int done_cyc, output int wr_cnt);
    int lines;
    int busy_cnt;
    logic [LINES_W-1:0] exp_lines;
    logic [COLS*CELL_W-1:0] got_row, want_row;
    compute_expected(lines);
    exp_q.push_back(LINES_W'(lines));
    run_pass(extra_cyc, done_cyc, busy_cnt, wr_cnt);
    exp_lines = exp_q.pop_front();
    check({tag, "_lines_at_done"}, 32'(bus.lines_cleared), 32'(exp_lines));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(done_cyc));
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_lines_held"}, 32'(bus.lines_cleared), 32'(exp_lines));
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        got_row[c*CELL_W +: CELL_W]  = board[r][c];
        want_row[c*CELL_W +: CELL_W] = exp_board[r][c];
      end
      check($sformatf("%s_row%0d", tag, r), 32'(got_row), 32'(want_row));
    end
`ifdef LINE_CLEAR_SCORE_EN
    exp_score = exp_score + points(lines);
    if (exp_score > 65535) exp_score = 65535;
`else
    exp_score = 0;
`endif
    check({tag, "_score"}, 32'(bus.score), 32'(exp_score));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int done_cyc;
    int wr_cnt;
    int wr_after;
    reset = 1'b1;
    bus.start = 1'b0;
    load_en = 1'b0;
    fill_empty();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_lines", 32'(bus.lines_cleared), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_rd_addr", 32'({bus.rd_row, bus.rd_col}), 32'd0);
    check("rst_wr_addr", 32'({bus.wr_row, bus.wr_col}), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_score", 32'(bus.score), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Empty board: done in cycle 21, no writes.
    fill_empty();
    load_board();
    check_pass("empty", 0, done_cyc, wr_cnt);
    check("empty_done_cycle", 32'(done_cyc), 32'd21);
    check("empty_wr_cycles", 32'(wr_cnt), 32'd0);

    // Row 19 full: 10 scan + 190 shift + 10 clear + 20 scan, done in 231.
    do_reset();
    fill_empty();
    fill_row(19, 3);
    load_board();
    check_pass("row19", 0, done_cyc, wr_cnt);
    check("row19_done_cycle", 32'(done_cyc), 32'd231);
    check("row19_wr_cycles", 32'(wr_cnt), 32'd200);

    // Rows 18/19 full, row 17 partial.
    do_reset();
    fill_empty();
    fill_row(19, 1);
    fill_row(18, 7);
    load_img[17][0] = 3'd1;
    load_img[17][1] = 3'd2;
    load_board();
    check_pass("two", 0, done_cyc, wr_cnt);

    // Reset in the middle of SHIFT aborts with no further writes.
    fill_empty();
    fill_row(19, 4);
    load_board();
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("mid_state_shift", 32'(dbg_state), 32'(ST_SHIFT));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_score = 0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("mid_rst_lines", 32'(bus.lines_cleared), 32'd0);
    check("mid_rst_score", 32'(bus.score), 32'd0);
    wr_after = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.wr_en || bus.busy) wr_after++;
    end
    check("mid_rst_quiet", 32'(wr_after), 32'd0);

    // Whole board full, then a second pass on the now-empty board.
    do_reset();
    fill_empty();
    for (int r = 0; r < ROWS; r++) fill_row(r, 5);
    load_board();
    check_pass("full", 0, done_cyc, wr_cnt);
    check_pass("full_again", 0, done_cyc, wr_cnt);
    check("full_again_done_cycle", 32'(done_cyc), 32'd21);

    // start while busy and start in the DONE cycle are both ignored.
    fill_empty();
    load_board();
    check_pass("restart_busy", 5, done_cyc, wr_cnt);
    check("restart_busy_done_cycle", 32'(done_cyc), 32'd21);
    check_pass("restart_done", 21, done_cyc, wr_cnt);
    check("restart_done_cycle", 32'(done_cyc), 32'd21);
    check("restart_done_state", 32'(dbg_state), 32'(ST_IDLE));

    // Random boards.
    for (int t = 0; t < 6; t++) begin
      fill_random();
      load_board();
      check_pass($sformatf("rand%0d", t), 0, done_cyc, wr_cnt);
    end

    // Score saturation through repeated 4-line passes.
    do_reset();
    for (int p = 0; p < 56; p++) begin
      fill_empty();
      for (int r = 16; r < ROWS; r++) fill_row(r, $urandom_range(1, 7));
      load_img[15][$urandom_range(0, COLS - 1)] = 3'd6;
      load_board();
      check_pass($sformatf("sat%0d", p), 0, done_cyc, wr_cnt);
    end
`ifdef LINE_CLEAR_SCORE_EN
    check("sat_final", 32'(bus.score), 32'hFFFF);
`else
    check("sat_final", 32'(bus.score), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
